// File: rtl/rs_decode_issue.sv
// -----------------------------------------------------------------------------
// rs_decode_issue
//
// Registered, handshaked decode/issue stage between one reservation-station
// output and one ALU lane. An accepted RS entry is decoded into ALU operands
// and control, which appear on the registered outputs one cycle later and
// hold until out_ready. beq/bne are resolved from the entry's own operands
// and reported as a one-cycle br_valid pulse. lw hits write back directly the
// cycle after acceptance; lw misses are queued in an in-order miss FIFO,
// requested from memory by a two-state FSM, and written back in request order
// as mem_resp_valid data returns.
//
// Optional build macro: RS_DECODE_SHIFT_EN
//   Defined   : R-type sll/srl/sra decode to 1001/1010/1011 with src_a=rt and
//               src_b = zero-extended shamt (rd/imm[10:6]).
//   Undefined : those functs decode as 0000 with normal R-type operands.
//
// Ports
//   Clk, Reset                 clock, synchronous active-high reset
//   in_valid/in_ready/in_entry RS entry handshake; entry fields MSB->LSB:
//                              {flag, tag, op, rs_flag, rs, rt_flag, rt,
//                               rdimm_flag, rd/imm, funct}
//   cache_hit/cache_data       combinational cache lookup for cache_addr
//   cache_addr                 rs + imm of the presented entry
//   out_valid/out_ready        ALU issue handshake
//   alu_ctrl,src_a,src_b,dest,reg_write  registered ALU operands/control
//   br_valid/br_taken/br_tag   branch resolution pulse
//   mem_req_valid/ready/addr   lw-miss request to memory
//   mem_resp_valid/data        in-order lw-miss data from memory
//   wb_valid/wb_dest/wb_data   load writeback pulse
// -----------------------------------------------------------------------------
module rs_decode_issue #(
  parameter  int DATA_W     = 32,
  parameter  int TAG_W      = 32,
  parameter  int MISS_DEPTH = 4,
  localparam int ENTRY_W    = 1 + TAG_W + 6 + 1 + DATA_W + 1 + DATA_W + 1 + DATA_W + 6
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ENTRY_W-1:0] in_entry,
  input  logic               cache_hit,
  input  logic [DATA_W-1:0]  cache_data,
  output logic [DATA_W-1:0]  cache_addr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [3:0]         alu_ctrl,
  output logic [DATA_W-1:0]  src_a,
  output logic [DATA_W-1:0]  src_b,
  output logic [DATA_W-1:0]  dest,
  output logic               reg_write,
  output logic               br_valid,
  output logic               br_taken,
  output logic [TAG_W-1:0]   br_tag,
  output logic               mem_req_valid,
  input  logic               mem_req_ready,
  output logic [DATA_W-1:0]  mem_req_addr,
  input  logic               mem_resp_valid,
  input  logic [DATA_W-1:0]  mem_resp_data,
  output logic               wb_valid,
  output logic [DATA_W-1:0]  wb_dest,
  output logic [DATA_W-1:0]  wb_data
);

  localparam int PTR_W = $clog2(MISS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef struct packed {
    logic              flag;
    logic [TAG_W-1:0]  tag;
    logic [5:0]        op;
    logic              rs_flag;
    logic [DATA_W-1:0] rs;
    logic              rt_flag;
    logic [DATA_W-1:0] rt;
    logic              rdimm_flag;
    logic [DATA_W-1:0] rdimm;
    logic [5:0]        funct;
  } rs_entry_t;

  typedef enum logic {S_IDLE, S_REQ} miss_state_e;

  rs_entry_t ent;
  assign ent        = in_entry;
  assign cache_addr = ent.rs + ent.rdimm;

  // ---------------------------------------------------------------------------
  // Decode of the presented entry
  // ---------------------------------------------------------------------------
  logic              dec_issue, dec_rw, is_branch, is_lw, br_taken_c;
  logic [3:0]        dec_alu;
  logic [DATA_W-1:0] dec_a, dec_b, dec_dest;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the case statements can leave it unassigned and infer a latch.
  always_comb begin
    dec_issue = 1'b1;
    dec_alu   = 4'b0000;
    dec_a     = ent.rs;
    dec_b     = ent.rdimm;
    dec_dest  = ent.rt;
    dec_rw    = 1'b0;
    is_branch = 1'b0;
    is_lw     = 1'b0;
    unique case (ent.op)
      OP_RTYPE: begin
        dec_b    = ent.rt;
        dec_dest = ent.rdimm;
        dec_rw   = 1'b1;
        case (ent.funct)
          6'b100000, 6'b100001: dec_alu = 4'b0010;
          6'b100010, 6'b100011: dec_alu = 4'b0110;
          6'b100100:            dec_alu = 4'b0000;
          6'b100101:            dec_alu = 4'b0001;
          6'b100110:            dec_alu = 4'b0011;
          6'b100111:            dec_alu = 4'b0100;
          6'b101010:            dec_alu = 4'b0111;
          6'b101011:            dec_alu = 4'b0101;
`ifdef RS_DECODE_SHIFT_EN
          // Shifts operate on rt by the shamt field sitting just above funct.
          6'b000000, 6'b000010, 6'b000011: begin
            dec_alu = (ent.funct == 6'b000000) ? 4'b1001 :
                      (ent.funct == 6'b000010) ? 4'b1010 : 4'b1011;
            dec_a   = ent.rt;
            dec_b   = {{(DATA_W-5){1'b0}}, ent.rdimm[10:6]};
          end
`endif
          default:              dec_alu = 4'b0000;
        endcase
      end
      OP_BEQ, OP_BNE: begin
        dec_alu   = 4'b0110;
        dec_b     = ent.rt;
        dec_dest  = ent.rdimm;
        is_branch = 1'b1;
      end
      OP_ADDI, OP_ADDIU: begin dec_alu = 4'b0010; dec_rw = 1'b1; end
      OP_SLTI:           begin dec_alu = 4'b0111; dec_rw = 1'b1; end
      OP_SLTIU:          begin dec_alu = 4'b0101; dec_rw = 1'b1; end
      OP_ANDI:           begin dec_alu = 4'b0000; dec_rw = 1'b1; end
      OP_ORI:            begin dec_alu = 4'b0001; dec_rw = 1'b1; end
      OP_XORI:           begin dec_alu = 4'b0011; dec_rw = 1'b1; end
      OP_LUI:            begin dec_alu = 4'b1000; dec_rw = 1'b1; end
      OP_SW:             dec_alu = 4'b0010;
      OP_LW: begin
        dec_issue = 1'b0;
        is_lw     = 1'b1;
      end
      default: ;
    endcase
  end

  // Branch outcome is taken from the entry itself, not from registered state.
  assign br_taken_c = (ent.op == OP_BNE) ? (ent.rs != ent.rt) : (ent.rs == ent.rt);

  // ---------------------------------------------------------------------------
  // Acceptance
  // ---------------------------------------------------------------------------
  miss_state_e       state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic              out_valid_q, out_valid_d;
  logic              fifo_full, fifo_empty, lw_hit, lw_miss, accept, push, pop;

  assign fifo_full  = (count_q == CNT_W'(MISS_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign lw_hit     = is_lw && cache_hit;
  assign lw_miss    = is_lw && !cache_hit;

  // A lw hit yields to a same-cycle memory response for the writeback port.
  assign in_ready = !(out_valid_q && !out_ready)
                 && !(lw_miss && (fifo_full || state_q != S_IDLE))
                 && !(lw_hit && mem_resp_valid);
  assign accept   = in_valid && in_ready && ent.flag;
  assign push     = accept && lw_miss;
  assign pop      = mem_resp_valid && !fifo_empty;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  logic [3:0]        alu_ctrl_q, alu_ctrl_d;
  logic [DATA_W-1:0] src_a_q, src_a_d, src_b_q, src_b_d, dest_q, dest_d;
  logic              reg_write_q, reg_write_d;
  logic              br_valid_q, br_valid_d, br_taken_q, br_taken_d;
  logic [TAG_W-1:0]  br_tag_q, br_tag_d;
  logic [DATA_W-1:0] req_addr_q, req_addr_d;
  logic              wb_valid_q, wb_valid_d;
  logic [DATA_W-1:0] wb_dest_q, wb_dest_d, wb_data_q, wb_data_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] fifo_mem [MISS_DEPTH];

  always_comb begin
    // ALU issue register: hold until consumed, reload on an issuing accept.
    out_valid_d = out_valid_q && !out_ready;
    alu_ctrl_d  = alu_ctrl_q;
    src_a_d     = src_a_q;
    src_b_d     = src_b_q;
    dest_d      = dest_q;
    reg_write_d = reg_write_q;
    if (accept && dec_issue) begin
      out_valid_d = 1'b1;
      alu_ctrl_d  = dec_alu;
      src_a_d     = dec_a;
      src_b_d     = dec_b;
      dest_d      = dec_dest;
      reg_write_d = dec_rw;
    end

    br_valid_d = accept && is_branch;
    br_taken_d = br_taken_q;
    br_tag_d   = br_tag_q;
    if (accept && is_branch) begin
      br_taken_d = br_taken_c;
      br_tag_d   = ent.tag;
    end

    // Miss FIFO bookkeeping; a push and pop together leave the count alone.
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (!push && pop) count_d = count_q - CNT_W'(1);
    err_d = err_q || (mem_resp_valid && fifo_empty);

    // Writeback: memory responses and lw hits never coincide (see in_ready).
    wb_valid_d = pop || (accept && lw_hit);
    wb_dest_d  = wb_dest_q;
    wb_data_d  = wb_data_q;
    if (pop) begin
      wb_dest_d = fifo_mem[rd_ptr_q];
      wb_data_d = mem_resp_data;
    end else if (accept && lw_hit) begin
      wb_dest_d = ent.rt;
      wb_data_d = cache_data;
    end

    state_d    = state_q;
    req_addr_d = req_addr_q;
    unique case (state_q)
      S_IDLE: if (push) begin
        state_d    = S_REQ;
        req_addr_d = cache_addr;
      end
      S_REQ:  if (mem_req_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      alu_ctrl_q  <= '0;
      src_a_q     <= '0;
      src_b_q     <= '0;
      dest_q      <= '0;
      reg_write_q <= 1'b0;
      br_valid_q  <= 1'b0;
      br_taken_q  <= 1'b0;
      br_tag_q    <= '0;
      req_addr_q  <= '0;
      wb_valid_q  <= 1'b0;
      wb_dest_q   <= '0;
      wb_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      alu_ctrl_q  <= alu_ctrl_d;
      src_a_q     <= src_a_d;
      src_b_q     <= src_b_d;
      dest_q      <= dest_d;
      reg_write_q <= reg_write_d;
      br_valid_q  <= br_valid_d;
      br_taken_q  <= br_taken_d;
      br_tag_q    <= br_tag_d;
      req_addr_q  <= req_addr_d;
      wb_valid_q  <= wb_valid_d;
      wb_dest_q   <= wb_dest_d;
      wb_data_q   <= wb_data_d;
    end
  end

  // NOTE: the FIFO storage has no reset; the count and pointers alone define
  // which slots are valid, so stale contents are never observed.
  always_ff @(posedge Clk) begin
    if (push) fifo_mem[wr_ptr_q] <= ent.rt;
  end

  assign out_valid     = out_valid_q;
  assign alu_ctrl      = alu_ctrl_q;
  assign src_a         = src_a_q;
  assign src_b         = src_b_q;
  assign dest          = dest_q;
  assign reg_write     = reg_write_q;
  assign br_valid      = br_valid_q;
  assign br_taken      = br_taken_q;
  assign br_tag        = br_tag_q;
  assign mem_req_valid = (state_q == S_REQ);
  assign mem_req_addr  = req_addr_q;
  assign wb_valid      = wb_valid_q;
  assign wb_dest       = wb_dest_q;
  assign wb_data       = wb_data_q;

  // Operand-ready flags and the orphan-response flag are not consumed here.
  logic unused_sink;
  assign unused_sink = ^{ent.rs_flag, ent.rt_flag, ent.rdimm_flag, err_q};

endmodule

// File: tb/tb_rs_decode_issue.sv
// -----------------------------------------------------------------------------
// tb_rs_decode_issue: directed self-checking bench for rs_decode_issue.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled at
// the same point, well away from the next active edge.
// -----------------------------------------------------------------------------
module tb_rs_decode_issue;
  localparam int DATA_W     = 32;
  localparam int TAG_W      = 32;
  localparam int MISS_DEPTH = 4;
  localparam int ENTRY_W    = 1 + TAG_W + 6 + 1 + DATA_W + 1 + DATA_W + 1 + DATA_W + 6;

  logic               Clk, Reset;
  logic               in_valid, in_ready;
  logic [ENTRY_W-1:0] in_entry;
  logic               cache_hit;
  logic [DATA_W-1:0]  cache_data, cache_addr;
  logic               out_valid, out_ready;
  logic [3:0]         alu_ctrl;
  logic [DATA_W-1:0]  src_a, src_b, dest;
  logic               reg_write, br_valid, br_taken;
  logic [TAG_W-1:0]   br_tag;
  logic               mem_req_valid, mem_req_ready;
  logic [DATA_W-1:0]  mem_req_addr;
  logic               mem_resp_valid;
  logic [DATA_W-1:0]  mem_resp_data;
  logic               wb_valid;
  logic [DATA_W-1:0]  wb_dest, wb_data;

  int compared   = 0;
  int mismatched = 0;

  rs_decode_issue #(.DATA_W(DATA_W), .TAG_W(TAG_W), .MISS_DEPTH(MISS_DEPTH)) dut (
    .Clk(Clk), .Reset(Reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_entry(in_entry),
    .cache_hit(cache_hit), .cache_data(cache_data), .cache_addr(cache_addr),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_ctrl(alu_ctrl), .src_a(src_a), .src_b(src_b), .dest(dest), .reg_write(reg_write),
    .br_valid(br_valid), .br_taken(br_taken), .br_tag(br_tag),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_data(wb_data)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [ENTRY_W-1:0] mk(input logic flag, input logic [5:0] op,
                                            input logic [31:0] rs, input logic [31:0] rt,
                                            input logic [31:0] rdimm, input logic [5:0] funct,
                                            input logic [31:0] tag);
    return {flag, tag, op, 1'b1, rs, 1'b1, rt, 1'b1, rdimm, funct};
  endfunction

  // Present an entry and wait (bounded) until the stage can accept it.
  task automatic present(input logic [ENTRY_W-1:0] e, input string tag);
    in_entry = e;
    in_valid = 1'b1;
    #1;
    for (int k = 0; k < 12; k++) begin
      if (in_ready) break;
      tick();
    end
    check(tag, 64'(in_ready), 64'd1);
  endtask

  initial begin
    Reset = 1'b1; in_valid = 1'b0; in_entry = '0; cache_hit = 1'b0; cache_data = '0;
    out_ready = 1'b1; mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
    tick(); tick();
    Reset = 1'b0;
    #1;

    // Reset state
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_br_valid",  64'(br_valid),  64'd0);
    check("rst_wb_valid",  64'(wb_valid),  64'd0);
    check("rst_req_valid", 64'(mem_req_valid), 64'd0);
    check("rst_alu_ctrl",  64'(alu_ctrl),  64'd0);
    check("rst_src_a",     64'(src_a),     64'd0);
    check("rst_wb_data",   64'(wb_data),   64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);

    // R-type add rs=5 rt=7 rd=3
    present(mk(1'b1, 6'b000000, 32'd5, 32'd7, 32'd3, 6'b100000, 32'd0), "add_ready");
    tick(); in_valid = 1'b0;
    check("add_valid", 64'(out_valid), 64'd1);
    check("add_alu",   64'(alu_ctrl),  64'h2);
    check("add_src_a", 64'(src_a),     64'd5);
    check("add_src_b", 64'(src_b),     64'd7);
    check("add_dest",  64'(dest),      64'd3);
    check("add_rw",    64'(reg_write), 64'd1);
    tick();
    check("add_drain", 64'(out_valid), 64'd0);

    // sub, then slt back to back
    present(mk(1'b1, 6'b000000, 32'd20, 32'd3, 32'd4, 6'b100010, 32'd0), "sub_ready");
    tick();
    check("sub_alu",  64'(alu_ctrl), 64'h6);
    present(mk(1'b1, 6'b000000, 32'd1, 32'd2, 32'd6, 6'b101010, 32'd0), "slt_ready");
    tick(); in_valid = 1'b0;
    check("slt_alu",  64'(alu_ctrl), 64'h7);
    check("slt_dest", 64'(dest),     64'd6);

    // ori: immediate operands, dest=rt
    present(mk(1'b1, 6'b001101, 32'h10, 32'd9, 32'hFF, 6'b000000, 32'd0), "ori_ready");
    tick(); in_valid = 1'b0;
    check("ori_alu",   64'(alu_ctrl),  64'h1);
    check("ori_src_b", 64'(src_b),     64'hFF);
    check("ori_dest",  64'(dest),      64'd9);
    check("ori_rw",    64'(reg_write), 64'd1);

    // lui and sw
    present(mk(1'b1, 6'b001111, 32'h0, 32'd2, 32'h1234, 6'b000000, 32'd0), "lui_ready");
    tick();
    check("lui_alu", 64'(alu_ctrl), 64'h8);
    present(mk(1'b1, 6'b101011, 32'h40, 32'd5, 32'h8, 6'b000000, 32'd0), "sw_ready");
    tick(); in_valid = 1'b0;
    check("sw_alu", 64'(alu_ctrl),  64'h2);
    check("sw_rw",  64'(reg_write), 64'd0);

    // sll funct=000000, shamt=5, rd=7
    present(mk(1'b1, 6'b000000, 32'h11, 32'h22, 32'h3940, 6'b000000, 32'd0), "sll_ready");
    tick(); in_valid = 1'b0;
`ifdef RS_DECODE_SHIFT_EN
    check("sll_alu",   64'(alu_ctrl), 64'h9);
    check("sll_src_a", 64'(src_a),    64'h22);
    check("sll_src_b", 64'(src_b),    64'd5);
`else
    check("sll_alu",   64'(alu_ctrl), 64'h0);
    check("sll_src_a", 64'(src_a),    64'h11);
    check("sll_src_b", 64'(src_b),    64'h22);
`endif
    check("sll_dest",  64'(dest),     64'h3940);

    // Unknown op issues with 0000, no register write
    present(mk(1'b1, 6'b111111, 32'h1, 32'h2, 32'h3, 6'b100000, 32'd0), "unk_ready");
    tick(); in_valid = 1'b0;
    check("unk_alu", 64'(alu_ctrl),  64'h0);
    check("unk_rw",  64'(reg_write), 64'd0);
    tick();

    // flag=0 entry is consumed with no effect
    present(mk(1'b0, 6'b000000, 32'd5, 32'd7, 32'd3, 6'b100000, 32'd0), "nf_ready");
    tick(); in_valid = 1'b0;
    check("nf_out_valid", 64'(out_valid), 64'd0);

    // beq taken, then bne not taken
    present(mk(1'b1, 6'b000100, 32'd9, 32'd9, 32'd0, 6'b000000, 32'h2A), "beq_ready");
    tick();
    check("beq_br_valid", 64'(br_valid),  64'd1);
    check("beq_taken",    64'(br_taken),  64'd1);
    check("beq_tag",      64'(br_tag),    64'h2A);
    check("beq_alu",      64'(alu_ctrl),  64'h6);
    check("beq_rw",       64'(reg_write), 64'd0);
    present(mk(1'b1, 6'b000101, 32'd9, 32'd9, 32'd0, 6'b000000, 32'h2B), "bne_ready");
    tick(); in_valid = 1'b0;
    check("bne_br_valid", 64'(br_valid), 64'd1);
    check("bne_taken",    64'(br_taken), 64'd0);
    check("bne_tag",      64'(br_tag),   64'h2B);
    tick();
    check("br_pulse_end", 64'(br_valid), 64'd0);

    // lw hit; first blocked by a concurrent (orphan) memory response
    cache_hit = 1'b1; cache_data = 32'hDEAD; mem_resp_valid = 1'b1; mem_resp_data = 32'h77;
    in_entry = mk(1'b1, 6'b100011, 32'h100, 32'd8, 32'd4, 6'b000000, 32'd0);
    in_valid = 1'b1;
    #1;
    check("lwhit_addr",     64'(cache_addr), 64'h104);
    check("lwhit_conflict", 64'(in_ready),   64'd0);
    tick();
    check("orphan_no_wb",   64'(wb_valid),   64'd0);
    mem_resp_valid = 1'b0;
    present(mk(1'b1, 6'b100011, 32'h100, 32'd8, 32'd4, 6'b000000, 32'd0), "lwhit_ready");
    tick(); in_valid = 1'b0; cache_hit = 1'b0;
    check("lwhit_wb_valid", 64'(wb_valid),  64'd1);
    check("lwhit_wb_dest",  64'(wb_dest),   64'd8);
    check("lwhit_wb_data",  64'(wb_data),   64'hDEAD);
    check("lwhit_no_issue", 64'(out_valid), 64'd0);
    tick();
    check("lwhit_pulse_end", 64'(wb_valid), 64'd0);

    // Four lw misses fill the FIFO, each producing a request
    mem_req_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      present(mk(1'b1, 6'b100011, 32'h200 + 32'(i * 16), 32'(i), 32'd0, 6'b000000, 32'd0),
              "miss_ready");
      tick(); in_valid = 1'b0;
      check("miss_req_valid", 64'(mem_req_valid), 64'd1);
      check("miss_req_addr",  64'(mem_req_addr),  64'h200 + 64'(i * 16));
      check("miss_no_issue",  64'(out_valid),     64'd0);
      tick();
    end

    // Fifth miss stalls on a full FIFO until a response pops the head
    in_entry = mk(1'b1, 6'b100011, 32'h250, 32'd5, 32'd0, 6'b000000, 32'd0);
    in_valid = 1'b1;
    #1;
    check("full_stall0", 64'(in_ready), 64'd0);
    tick();
    check("full_stall1", 64'(in_ready), 64'd0);
    mem_resp_valid = 1'b1; mem_resp_data = 32'hA;
    #1;
    check("full_stall2", 64'(in_ready), 64'd0);
    tick(); mem_resp_valid = 1'b0;
    check("resp1_valid", 64'(wb_valid), 64'd1);
    check("resp1_dest",  64'(wb_dest),  64'd1);
    check("resp1_data",  64'(wb_data),  64'hA);
    #1;
    check("fifth_ready", 64'(in_ready), 64'd1);
    tick(); in_valid = 1'b0;
    check("fifth_req_valid", 64'(mem_req_valid), 64'd1);
    check("fifth_req_addr",  64'(mem_req_addr),  64'h250);
    tick();

    // Remaining responses return in request order, across the pointer wrap
    for (int i = 2; i <= 5; i++) begin
      mem_resp_valid = 1'b1; mem_resp_data = 32'h9 + 32'(i);
      tick();
      check("resp_valid", 64'(wb_valid), 64'd1);
      check("resp_dest",  64'(wb_dest),  64'(i));
      check("resp_data",  64'(wb_data),  64'h9 + 64'(i));
    end
    mem_resp_valid = 1'b0;
    tick();
    check("resp_pulse_end", 64'(wb_valid), 64'd0);

    // Backpressure: outputs hold for three cycles, next entry issues after release
    out_ready = 1'b0;
    present(mk(1'b1, 6'b000000, 32'd1, 32'd2, 32'd3, 6'b100000, 32'd0), "bp_a_ready");
    tick();
    in_entry = mk(1'b1, 6'b000000, 32'd10, 32'd4, 32'd6, 6'b100010, 32'd0);
    #1;
    check("bp_in_ready", 64'(in_ready), 64'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("bp_hold_valid", 64'(out_valid), 64'd1);
      check("bp_hold_src_a", 64'(src_a),     64'd1);
      check("bp_hold_alu",   64'(alu_ctrl),  64'h2);
      check("bp_hold_ready", 64'(in_ready),  64'd0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 64'(in_ready), 64'd1);
    tick(); in_valid = 1'b0;
    check("bp_b_valid", 64'(out_valid), 64'd1);
    check("bp_b_alu",   64'(alu_ctrl),  64'h6);
    check("bp_b_src_a", 64'(src_a),     64'd10);
    tick();
    check("bp_drain", 64'(out_valid), 64'd0);

    // Reset while REQ with two queued misses
    mem_req_ready = 1'b1;
    present(mk(1'b1, 6'b100011, 32'h300, 32'd11, 32'd0, 6'b000000, 32'd0), "rm1_ready");
    tick(); in_valid = 1'b0;
    tick();
    mem_req_ready = 1'b0;
    present(mk(1'b1, 6'b100011, 32'h310, 32'd12, 32'd0, 6'b000000, 32'd0), "rm2_ready");
    tick(); in_valid = 1'b0;
    tick();
    check("rm_req_held", 64'(mem_req_valid), 64'd1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("rm_req_cleared", 64'(mem_req_valid), 64'd0);
    check("rm_wb_clear",    64'(wb_valid),      64'd0);
    check("rm_addr_clear",  64'(mem_req_addr),  64'd0);
    mem_resp_valid = 1'b1; mem_resp_data = 32'h55;
    tick();
    mem_resp_valid = 1'b0;
    check("rm_no_wb", 64'(wb_valid), 64'd0);
    tick();
    check("rm_no_wb2", 64'(wb_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
